// File: rtl/poly_eval_mac.sv
// Horner-method polynomial evaluator with a single MAC.
// Supports runtime degree, derivative mode and sticky overflow.
module poly_eval_mac #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int MAX_DEG = 4,
  localparam int DEG_W  = $clog2(MAX_DEG + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [DEG_W-1:0]              in_deg,
  input  logic [DATA_W-1:0]             in_x,
  input  logic [(MAX_DEG+1)*DATA_W-1:0] in_coef,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RES_W-1:0]              result,
  output logic                          out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int NC = MAX_DEG + 1;
  localparam int KW = DEG_W + 1;
  localparam int DW = DATA_W + KW;
  localparam int XW = DW + RES_W;
  localparam int PW = RES_W + DATA_W;
  localparam logic [DEG_W-1:0] MAXD = DEG_W'(MAX_DEG);

  state_t state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [DEG_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [RES_W-1:0] coef_q [NC];
  logic [RES_W-1:0] coef_d [NC];
  logic ovf_q, ovf_d;
  logic out_ovf_q, out_ovf_d;
  logic out_valid_q, out_valid_d;

  logic [(NC+1)*DATA_W-1:0] coef_x;
  logic [DEG_W-1:0] n_eff, e_eff;
  logic [RES_W-1:0] ceff [NC];
  logic [DW-1:0] dprod;
  logic [XW-1:0] dext;
  logic trunc;

  assign coef_x = {{DATA_W{1'b0}}, in_coef};

  // Effective coefficient set for the requested mode, built at accept time
  always_comb begin
    n_eff = (in_deg > MAXD) ? MAXD : in_deg;
    e_eff = n_eff;
    if (in_mode) begin
      e_eff = (n_eff == '0) ? '0 : n_eff - 1'b1;
    end
    trunc = 1'b0;
    dprod = '0;
    dext  = '0;
    for (int k = 0; k < NC; k++) begin
      ceff[k] = RES_W'(coef_x[k*DATA_W +: DATA_W]);
      if (in_mode) begin
        if (k < MAX_DEG) begin
          dprod = DW'(k + 1) * DW'(coef_x[(k+1)*DATA_W +: DATA_W]);
          dext  = XW'(dprod);
          ceff[k] = dext[RES_W-1:0];
          if ((DEG_W'(k) < n_eff) && (dext[XW-1:RES_W] != '0)) begin
            trunc = 1'b1;
          end
        end else begin
          ceff[k] = '0;
        end
      end
    end
    if (in_mode && (n_eff == '0)) begin
      ceff[0] = '0;
    end
  end

  logic [PW-1:0] mul;
  logic [RES_W:0] sum;
  logic [DEG_W-1:0] cidx;
  logic step_ovf;

  assign cidx = cnt_q - 1'b1;
  assign mul = PW'(acc_q) * PW'(x_q);
  assign sum = {1'b0, mul[RES_W-1:0]} + {1'b0, coef_q[cidx]};
  assign step_ovf = (mul[PW-1:RES_W] != '0) || sum[RES_W];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    coef_d      = coef_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          coef_d  = ceff;
          acc_d   = ceff[e_eff];
          cnt_d   = e_eff;
          ovf_d   = trunc;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          acc_d = sum[RES_W-1:0];
          cnt_d = cidx;
          ovf_d = ovf_q | step_ovf;
        end
      end
      DONE: begin
        // First DONE cycle publishes the result; the handshake follows
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          result_d    = acc_q;
          out_ovf_d   = ovf_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < NC; k++) begin
        coef_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      coef_q      <= coef_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_poly_eval_mac.sv
// Directed and randomised checks of poly_eval_mac.
// Reference model evaluates the polynomial by powers of x.
module tb_poly_eval_mac;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_deg = '0;
  logic [7:0]  in_x = '0;
  logic [39:0] in_coef = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ovf;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  poly_eval_mac #(
    .DATA_W (8),
    .RES_W  (16),
    .MAX_DEG(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_deg   (in_deg),
    .in_x     (in_x),
    .in_coef  (in_coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_ovf  (out_ovf)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] pack(input int a0, input int a1,
                                       input int a2, input int a3,
                                       input int a4);
    pack = {a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic void model(input bit mode, input int deg,
                                input int x, input logic [39:0] coef,
                                output int res, output bit ovf,
                                output int e);
    longint a[6];
    longint c[5];
    longint acc, p, s, pw, sv;
    int n;
    for (int k = 0; k < 5; k++) begin
      a[k] = longint'(coef[k*8 +: 8]);
      c[k] = 0;
    end
    a[5] = 0;
    n = (deg > 4) ? 4 : deg;
    ovf = 1'b0;
    if (!mode) begin
      e = n;
      for (int k = 0; k <= n; k++) c[k] = a[k];
    end else if (n == 0) begin
      e = 0;
      c[0] = 0;
    end else begin
      e = n - 1;
      for (int k = 0; k < n; k++) begin
        c[k] = (k + 1) * a[k+1];
        if (c[k] > 65535) ovf = 1'b1;
        c[k] = c[k] % 65536;
      end
    end
    sv = 0;
    pw = 1;
    for (int k = 0; k <= e; k++) begin
      sv = (sv + c[k] * pw) % 65536;
      pw = (pw * x) % 65536;
    end
    res = int'(sv);
    acc = c[e];
    for (int k = e - 1; k >= 0; k--) begin
      p = acc * x;
      if (p > 65535) ovf = 1'b1;
      p = p % 65536;
      s = p + c[k];
      if (s > 65535) ovf = 1'b1;
      acc = s % 65536;
    end
  endfunction

  task automatic send(input bit mode, input int deg, input int x,
                      input logic [39:0] coef);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    chk("ready_wait_in_bound", (w < 100), 1);
    in_valid = 1'b1;
    in_mode  = mode;
    in_deg   = deg[2:0];
    in_x     = x[7:0];
    in_coef  = coef;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic txn(input string tag, input bit mode, input int deg,
                     input int x, input logic [39:0] coef,
                     input int want_res, input int want_ovf);
    int res, e, lat;
    bit ovf;
    model(mode, deg, x, coef, res, ovf, e);
    send(mode, deg, x, coef);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, e + 2);
    chk({tag, "_res"}, result, res);
    chk({tag, "_ovf"}, out_ovf, ovf);
    if (want_res >= 0) chk({tag, "_res_dir"}, result, want_res);
    if (want_ovf >= 0) chk({tag, "_ovf_dir"}, out_ovf, want_ovf);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, in_ready, 1);
    chk({tag, "_idle_vld"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    int seen;
    bit m;
    int d, xv;
    logic [39:0] cf;

    reset = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_out_ovf", out_ovf, 0);

    txn("q431", 0, 2, 8, pack(7, 13, 5, 0, 0), 431, 0);
    txn("q_x0", 0, 2, 0, pack(3, 2, 1, 0, 0), 3, 0);
    txn("q482", 0, 2, 4, pack(10, 18, 25, 0, 0), 482, 0);
    txn("d93", 1, 2, 8, pack(7, 13, 5, 0, 0), 93, 0);
    txn("d_n0", 1, 0, 8, pack(7, 13, 5, 0, 0), 0, 0);
    txn("c9", 0, 0, 3, pack(9, 4, 4, 4, 4), 9, 0);
    txn("ovf", 0, 4, 255, pack(255, 255, 255, 255, 255), -1, 1);
    txn("clean", 0, 2, 5, pack(1, 2, 3, 0, 0), 86, 0);
    txn("ovf2", 0, 4, 255, pack(255, 255, 255, 255, 255), -1, 1);

    send(0, 4, 200, pack(11, 22, 33, 44, 55));
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_out_ovf", out_ovf, 0);
    seen = 0;
    repeat (10) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);

    send(0, 2, 8, pack(7, 13, 5, 0, 0));
    wait_valid(lat);
    chk("bp_lat", lat, 4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_x     = 8'($urandom);
      in_coef  = {$urandom, 8'($urandom)};
      tick();
      chk("bp_result", result, 431);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_rdy", in_ready, 1);
    txn("b2b", 0, 2, 4, pack(10, 18, 25, 0, 0), 482, 0);

    txn("clamp", 0, 7, 2, pack(1, 1, 1, 1, 1), 31, 0);
    txn("clamp_d", 1, 6, 2, pack(1, 1, 1, 1, 1), 49, 0);

    for (int i = 0; i < 40; i++) begin
      m  = 1'($urandom);
      d  = $urandom_range(0, 7);
      xv = $urandom_range(0, 255);
      cf = {$urandom, 8'($urandom)};
      txn("rand", m, d, xv, cf, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_eval_mac.md
Name: poly_eval_mac

Overview:
- Parametrised successor to the fixed quadratic evaluator (a*x^2 + b*x + c).
- Evaluates an unsigned polynomial of runtime-selectable degree (0..MAX_DEG) at point x, using a single multiply-accumulate unit iterated by Horner's method.
- Adds a derivative mode, valid/ready handshakes on both sides, and a sticky overflow flag.
- Sits in the arithmetic datapath wherever quadratic_equation-style evaluation was used; drop-in for degree 2.

Parameters:
- DATA_W, 8, width of x and of each coefficient (unsigned).
- RES_W, 16, width of accumulator and result (unsigned).
- MAX_DEG, 4, maximum polynomial degree supported (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_mode  input  1  0 = evaluate p(x), 1 = evaluate p'(x).
- in_deg  input  clog2(MAX_DEG+1)  polynomial degree n.
- in_x  input  DATA_W  evaluation point.
- in_coef  input  (MAX_DEG+1)*DATA_W  coefficient a_k at bits [k*DATA_W +: DATA_W].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  RES_W  p(x) or p'(x) modulo 2^RES_W.
- out_ovf  output  1  an intermediate value exceeded RES_W bits in this transaction.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (reset==0 at clk edge, any state, including mid-CALC): state=IDLE, in_ready=1, out_valid=0, result=0, out_ovf=0, accumulator/counter cleared. The in-flight transaction is discarded.
- in_ready = 1 only in IDLE. Accept occurs on an edge with in_valid && in_ready.
- On accept, latch in_x, in_coef, in_mode, and n = min(in_deg, MAX_DEG). in_deg > MAX_DEG is clamped silently.
- Effective coefficient set:
  - mode 0: c_k = a_k, k = 0..n, effective degree e = n.
  - mode 1: c_k = (k+1)*a_{k+1}, k = 0..n-1, e = n-1. Each product is zero-extended/truncated to RES_W; truncation sets ovf.
  - mode 1 with n = 0: result = 0, e treated as 0 with c_0 = 0.
- Accept edge: acc <= c_e, cnt <= e, ovf <= 0; go to CALC.
- CALC, each cycle:
  - if cnt == 0: go to DONE.
  - else: acc <= acc*x + c_{cnt-1} (mod 2^RES_W); cnt <= cnt-1. ovf is set if the full-width product, or the sum, exceeds 2^RES_W - 1.
- DONE: out_valid=1; result and out_ovf hold stable until an edge with out_ready=1, then go to IDLE (out_valid=0, in_ready=1 next cycle). result and out_ovf keep their last values while in IDLE.
- Latency: out_valid rises e+2 cycles after the accept edge (degree 2, mode 0: 4 cycles). Minimum issue interval is e+4 cycles with out_ready held high.
- x = 0: Horner still iterates e times; result = c_0.
- in_valid while busy is ignored (no accept). The requester must hold its request until in_ready.
- out_ready asserted outside DONE has no effect.
- All arithmetic is unsigned; no saturation, wrap only.

Test Plan:
- Reset held low 5 cycles, then release -> in_ready=1, out_valid=0, result=0, out_ovf=0. Reset asserted mid-CALC -> IDLE next edge, no out_valid.
- mode 0, n=2, coef {a0=7,a1=13,a2=5}, x=8 -> result=431, out_ovf=0, out_valid exactly 4 cycles after accept. Then {3,2,1}, x=0 -> 3. Then {10,18,25}, x=4 -> 482.
- mode 1, n=2, coef {7,13,5}, x=8 -> result=93. mode 1, n=0 -> result=0. mode 0, n=0, a0=9 -> result=9 with latency 2.
- Overflow (RES_W=16): mode 0, n=4, all coef=255, x=255 -> out_ovf=1, result equal to the true value mod 65536. The next clean transaction -> out_ovf=0.
- Backpressure: out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE; a back-to-back request is then accepted.
- in_deg=7 with MAX_DEG=4 -> evaluated as degree 4. Cross-check randomised coefficients against a reference model, mod 2^RES_W.
